// File: rtl/ram_dma_ci_pkg.sv
// Shared definitions for the ram_dma_ci custom-instruction slave: command word
// field layout, memory geometry and a command decode helper.
package ram_dma_ci_pkg;

  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 512;

  localparam int ADDR_LSB  = 0;
  localparam int ADDR_W    = 9;
  localparam int WE_BIT    = 9;
  localparam int FUNC_LSB  = 10;
  localparam int FUNC_W    = 3;

  localparam logic [FUNC_W-1:0] FUNC_MEM = 3'd0;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic              we;
    logic [ADDR_W-1:0] addr;
  } ci_cmd_t;

  // Bits above the function field are ignored so they can never alias into the address.
  function automatic ci_cmd_t decode_cmd(input logic [DATA_W-1:0] a);
    ci_cmd_t c;
    c.addr = a[ADDR_LSB +: ADDR_W];
    c.we   = a[WE_BIT];
    c.func = a[FUNC_LSB +: FUNC_W];
    return c;
  endfunction

endpackage

// File: rtl/ram_dma_ci_memory.sv
// Single-clock scratch RAM: one write port and one registered read port, no reset
// on the storage or read register so it maps onto block RAM.
module ram_dma_memory
  import ram_dma_ci_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH,
  parameter int AW    = ADDR_W,
  parameter int DW    = DATA_W
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_dma_ci.sv
// Custom-instruction slave around a 512x32 scratch RAM. Writes and reserved
// functions finish in the issue cycle; reads return data one cycle later.
module ram_dma_ci
  import ram_dma_ci_pkg::*;
#(
  parameter logic [7:0] customId = 8'd14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        ciN,
  input  logic [DATA_W-1:0] valueA,
  input  logic [DATA_W-1:0] valueB,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  ci_cmd_t           w_cmd;
  logic              w_sel;
  logic              w_is_mem;
  logic              w_wr;
  logic              w_rd;
  logic              w_comb_done;
  logic [DATA_W-1:0] w_rdata;
  logic              r_read_pending;

  assign w_cmd    = decode_cmd(valueA);
  assign w_sel    = start & (ciN == customId);
  assign w_is_mem = (w_cmd.func == FUNC_MEM);
  assign w_wr     = w_sel & w_is_mem &  w_cmd.we;
  assign w_rd     = w_sel & w_is_mem & ~w_cmd.we;

  // Everything except a memory read completes in the issue cycle.
  assign w_comb_done = w_sel & ~w_rd;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_read_pending <= 1'b0;
    else        r_read_pending <= w_rd;
  end

  ram_dma_memory #(
    .DEPTH (MEM_DEPTH),
    .AW    (ADDR_W),
    .DW    (DATA_W)
  ) u_mem (
    .clock   (clock),
    .i_we    (w_wr),
    .i_waddr (w_cmd.addr),
    .i_wdata (valueB),
    .i_re    (w_rd),
    .i_raddr (w_cmd.addr),
    .o_rdata (w_rdata)
  );

  // A write issued while a read completes still shows the read data on result.
  assign done   = r_read_pending | w_comb_done;
  assign result = r_read_pending ? w_rdata : '0;

endmodule

// File: tb/tb_ram_dma_ci.sv
// Scoreboard bench for ram_dma_ci: stimulus pushes expected done pulses into a
// queue, a negedge monitor checks done/result every cycle against it.
module tb_ram_dma_ci;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  ram_dma_ci #(.customId(8'd14)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .ciN    (ciN),
    .valueA (valueA),
    .valueB (valueB),
    .done   (done),
    .result (result)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          known;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl_mem   [512];
  bit          mdl_known [512];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=0x%08h exp=0x%08h", name, cyc, got, exp);
  endtask

  // Reference model: an address-indexed array; each accepted op schedules one
  // expected done pulse (reads one cycle later, everything else immediately).
  task automatic op(input bit st, input logic [7:0] ci, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   addr;
    start = st; ciN = ci; valueA = a; valueB = b;
    if (st && ci == 8'd14) begin
      addr = int'(a[8:0]);
      if (a[12:10] != 3'd0) begin
        e.cyc = cyc; e.data = 32'h0; e.known = 1'b1;
      end else if (a[9]) begin
        mdl_mem[addr] = b; mdl_known[addr] = 1'b1;
        e.cyc = cyc; e.data = 32'h0; e.known = 1'b1;
      end else begin
        e.cyc = cyc + 1; e.data = mdl_mem[addr]; e.known = mdl_known[addr];
      end
      sbq.push_back(e);
    end
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 8'd0, 32'h0, 32'h0);
  endtask

  // Monitor: every cycle, collect all pulses due now; several due together merge
  // into a single done with the read data ORed in.
  always @(negedge clock) begin
    logic        exp_done;
    logic [31:0] exp_res;
    bit          res_known;
    exp_t        e;
    exp_done = 1'b0; exp_res = 32'h0; res_known = 1'b1;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      if (e.cyc < cyc) check("late_pulse", 32'(e.cyc), 32'(cyc));
      exp_done = 1'b1;
      exp_res  = exp_res | e.data;
      if (!e.known) res_known = 1'b0;
    end
    check("done", {31'h0, done}, {31'h0, exp_done});
    if (res_known) check("result", result, exp_res);
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 512; i++) begin mdl_mem[i] = 32'h0; mdl_known[i] = 1'b0; end
    reset = 1'b0; start = 1'b0; ciN = 8'd0; valueA = 32'h0; valueB = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    op(1'b0, 8'd7,  32'h200, 32'h42);
    op(1'b1, 8'd7,  32'h200, 32'h42);
    op(1'b0, 8'd14, 32'h200, 32'h42);

    op(1'b1, 8'd14, 32'h200, 32'h42);
    op(1'b1, 8'd14, 32'h000, 32'h0);
    idle(1);

    op(1'b1, 8'd14, 32'h237, 32'h57);
    op(1'b1, 8'd14, 32'h037, 32'h0);
    idle(1);
    op(1'b1, 8'd14, 32'h000, 32'h0);
    idle(1);

    op(1'b1, 8'd14, 32'h000, 32'h0);
    op(1'b1, 8'd14, 32'h037, 32'h0);
    idle(1);

    // Write landing in a read's done cycle, then read-after-write.
    op(1'b1, 8'd14, 32'h000, 32'h0);
    op(1'b1, 8'd14, 32'h255, 32'h99);
    op(1'b1, 8'd14, 32'h055, 32'h0);
    idle(1);

    op(1'b1, 8'd14, 32'h400, 32'h1234);
    op(1'b1, 8'd14, 32'h000, 32'h0);
    idle(1);

    op(1'b1, 8'd14, 32'h3FF, 32'hA5);
    op(1'b1, 8'd14, 32'h1FF, 32'h0);
    idle(1);
    op(1'b1, 8'd14, 32'hFFFF_E037, 32'h0);
    idle(1);

    // Reset during a pending read: the pulse must vanish and never reappear.
    op(1'b1, 8'd14, 32'h000, 32'h0);
    start = 1'b0;
    reset = 1'b0;
    sbq.delete();
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    idle(3);

    for (int i = 0; i < 400; i++) begin
      bit          st;
      logic [7:0]  ci;
      logic [2:0]  fn;
      logic        we;
      logic [8:0]  ad;
      logic [18:0] up;
      st = ($urandom_range(0, 9) != 0);
      ci = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'd14;
      fn = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      we = 1'($urandom);
      ad = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
      up = 19'($urandom);
      op(st, ci, {up, fn, we, ad}, $urandom);
    end

    idle(3);
    check("sb_drain", 32'(sbq.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
